// File: rtl/border_renderer.sv
// Registered playfield border renderer with off-screen masking and a
// frame-counted flash sequencer that blinks the border on request.
module border_renderer #(
    parameter int         BIT          = 10,
    parameter int         H_ACTIVE     = 640,
    parameter int         V_ACTIVE     = 480,
    parameter int         THICK_BITS   = 4,
    parameter logic [2:0] COLOR        = 3'b111,
    parameter logic [2:0] FLASH_COLOR  = 3'b100,
    parameter int         FLASH_FRAMES = 8,
    parameter int         FLASH_CYCLES = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [BIT-1:0] x_pos,
    input  logic [BIT-1:0] y_pos,
    input  logic           frame_start,
    input  logic           flash_req,
    output logic           border_active,
    output logic [2:0]     rgb,
    output logic           flash_busy
);

    localparam int SW = BIT - THICK_BITS;
    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam int CW = (FLASH_CYCLES > 0) ? $clog2(FLASH_CYCLES + 1) : 1;

    localparam logic [BIT-1:0] H_LIM      = BIT'(H_ACTIVE);
    localparam logic [BIT-1:0] V_LIM      = BIT'(V_ACTIVE);
    localparam logic [SW-1:0]  XS_MAX     = SW'((H_ACTIVE - 1) >> THICK_BITS);
    localparam logic [SW-1:0]  YS_MAX     = SW'((V_ACTIVE - 1) >> THICK_BITS);
    localparam logic [FW-1:0]  FRAME_LAST = FW'(FLASH_FRAMES - 1);
    localparam logic [CW-1:0]  CYC_LAST   = CW'(FLASH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FLASH_ON,
        FLASH_OFF
    } state_t;

    state_t        state;
    logic [FW-1:0] frame_cnt;
    logic [CW-1:0] cyc_cnt;

    logic          on;
    logic          hit;
    logic [SW-1:0] xs;
    logic [SW-1:0] ys;

    // Tile coordinates: the border is the outermost ring of 2^THICK_BITS tiles.
    assign xs  = x_pos[BIT-1:THICK_BITS];
    assign ys  = y_pos[BIT-1:THICK_BITS];
    assign on  = (x_pos < H_LIM) && (y_pos < V_LIM);
    assign hit = on && ((xs == '0) || (xs == XS_MAX) || (ys == '0) || (ys == YS_MAX));

    // Pixel outputs use the state as it stood before this edge; a flash
    // request always wins over a coincident frame_start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            frame_cnt     <= '0;
            cyc_cnt       <= '0;
            border_active <= 1'b0;
            rgb           <= 3'b000;
            flash_busy    <= 1'b0;
        end else begin
            unique case (state)
                FLASH_ON: begin
                    border_active <= hit;
                    rgb           <= hit ? FLASH_COLOR : 3'b000;
                end
                FLASH_OFF: begin
                    border_active <= 1'b0;
                    rgb           <= 3'b000;
                end
                default: begin
                    border_active <= hit;
                    rgb           <= hit ? COLOR : 3'b000;
                end
            endcase

            if (flash_req) begin
                state      <= FLASH_ON;
                frame_cnt  <= '0;
                cyc_cnt    <= '0;
                flash_busy <= 1'b1;
            end else if (frame_start && (state != IDLE)) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt <= '0;
                    if (state == FLASH_ON) begin
                        state <= FLASH_OFF;
                    end else if (cyc_cnt == CYC_LAST) begin
                        state      <= IDLE;
                        cyc_cnt    <= '0;
                        flash_busy <= 1'b0;
                    end else begin
                        state   <= FLASH_ON;
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_border_renderer.sv
// Directed self-checking bench for border_renderer: border geometry,
// off-screen masking, flash sequencing, retrigger, priority and async reset.
module tb_border_renderer;

    localparam int SEQ_FRAMES = 64;
    localparam int PHASE      = 8;

    logic       clk;
    logic       reset;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic       frame_start;
    logic       flash_req;
    logic       border_active;
    logic [2:0] rgb;
    logic       flash_busy;

    int vectors;
    int miscompares;

    border_renderer dut (
        .clk          (clk),
        .reset        (reset),
        .x_pos        (x_pos),
        .y_pos        (y_pos),
        .frame_start  (frame_start),
        .flash_req    (flash_req),
        .border_active(border_active),
        .rgb          (rgb),
        .flash_busy   (flash_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then settle just after the capturing edge.
    task automatic applyStimulus(input int x, input int y, input logic fs, input logic fr);
        x_pos       = 10'(x);
        y_pos       = 10'(y);
        frame_start = fs;
        flash_req   = fr;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        flash_req   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic exp_act,
                               input logic [2:0] exp_rgb, input logic exp_busy);
        vectors++;
        assert ({border_active, rgb, flash_busy} === {exp_act, exp_rgb, exp_busy})
        else begin
            miscompares++;
            $error("[TB] FAIL %s: active/rgb/busy observed %b/%b/%b expected %b/%b/%b",
                   tag, border_active, rgb, flash_busy, exp_act, exp_rgb, exp_busy);
        end
    endtask

    // Expected outputs at pixel (0,0) after k frame_starts into a sequence.
    task automatic frameAndCheck(input string tag, input int k);
        logic in_on;
        applyStimulus(0, 0, 1'b1, 1'b0);
        applyStimulus(0, 0, 1'b0, 1'b0);
        in_on = ((k / PHASE) % 2) == 0;
        if (k >= SEQ_FRAMES)
            checkOutput($sformatf("%s_k%0d", tag, k), 1'b1, 3'b111, 1'b0);
        else if (in_on)
            checkOutput($sformatf("%s_k%0d", tag, k), 1'b1, 3'b100, 1'b1);
        else
            checkOutput($sformatf("%s_k%0d", tag, k), 1'b0, 3'b000, 1'b1);
    endtask

    typedef struct {
        int         x;
        int         y;
        logic       act;
        logic [2:0] col;
    } pix_t;

    pix_t sweep[10] = '{
        '{0,   100, 1'b1, 3'b111},
        '{15,  100, 1'b1, 3'b111},
        '{16,  100, 1'b0, 3'b000},
        '{623, 200, 1'b0, 3'b000},
        '{624, 200, 1'b1, 3'b111},
        '{639, 200, 1'b1, 3'b111},
        '{320, 479, 1'b1, 3'b111},
        '{320, 463, 1'b0, 3'b000},
        '{700, 10,  1'b0, 3'b000},
        '{10,  500, 1'b0, 3'b000}
    };

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        x_pos       = '0;
        y_pos       = '0;
        frame_start = 1'b0;
        flash_req   = 1'b0;
        #1;
        checkOutput("reset_state", 1'b0, 3'b000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(sweep[i].x, sweep[i].y, 1'b0, 1'b0);
            checkOutput($sformatf("sweep_%0d_%0d", sweep[i].x, sweep[i].y),
                        sweep[i].act, sweep[i].col, 1'b0);
        end

        $display("[TB] full flash sequence");
        applyStimulus(0, 0, 1'b0, 1'b1);
        checkOutput("req_edge", 1'b1, 3'b111, 1'b1);
        applyStimulus(0, 0, 1'b0, 1'b0);
        checkOutput("first_flash_pixel", 1'b1, 3'b100, 1'b1);
        for (int k = 1; k <= SEQ_FRAMES; k++) frameAndCheck("seq", k);

        $display("[TB] retrigger after 20 frames");
        applyStimulus(0, 0, 1'b0, 1'b1);
        for (int k = 1; k <= 20; k++) frameAndCheck("pre_retrig", k);
        applyStimulus(0, 0, 1'b0, 1'b1);
        applyStimulus(0, 0, 1'b0, 1'b0);
        checkOutput("retrig_on", 1'b1, 3'b100, 1'b1);
        for (int k = 1; k <= SEQ_FRAMES; k++) frameAndCheck("retrig", k);

        $display("[TB] flash_req with frame_start at end of off phase");
        applyStimulus(0, 0, 1'b0, 1'b1);
        for (int k = 1; k <= 15; k++) frameAndCheck("pre_sim", k);
        applyStimulus(0, 0, 1'b1, 1'b1);
        applyStimulus(0, 0, 1'b0, 1'b0);
        checkOutput("sim_restart_on", 1'b1, 3'b100, 1'b1);
        for (int k = 1; k <= SEQ_FRAMES; k++) frameAndCheck("sim", k);

        $display("[TB] async reset mid-flash");
        applyStimulus(0, 0, 1'b0, 1'b1);
        for (int k = 1; k <= 10; k++) frameAndCheck("pre_rst", k);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", 1'b0, 3'b000, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(0, 0, 1'b0, 1'b0);
        checkOutput("post_reset_pixel", 1'b1, 3'b111, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/border_renderer.md
# border_renderer

Parametrised playfield border renderer for the snake VGA pipeline. It sits between the pixel-position generator and the colour mux. Each pixel, it decides whether the current pixel lies on the screen border and what colour to draw there. Unlike the plain combinational border, outputs are registered, off-screen positions are masked, and a frame-counted flash sequencer makes the border blink when gameplay requests it (e.g. on collision or game over).

## Interface
Parameters:
- BIT, 10, width of x_pos / y_pos
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- THICK_BITS, 4, border thickness is 2^THICK_BITS pixels
- COLOR, 3'b111, normal border colour
- FLASH_COLOR, 3'b100, border colour during the flash-on phase
- FLASH_FRAMES, 8, frames per flash phase (on or off), must be ≥1
- FLASH_CYCLES, 4, on/off pairs per flash sequence, must be ≥1

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- x_pos  in  BIT  current pixel column
- y_pos  in  BIT  current pixel row
- frame_start  in  1  one-cycle pulse at the start of each frame
- flash_req  in  1  one-cycle pulse that starts or restarts a flash sequence
- border_active  out  1  registered border hit for the pixel sampled on the previous cycle
- rgb  out  3  registered border colour, 3'b000 when border_active=0
- flash_busy  out  1  high while a flash sequence runs

## Operation
- Visible check: on = (x_pos < H_ACTIVE) && (y_pos < V_ACTIVE). Off-screen positions never hit the border.
- Border hit (hit) = on && (xs == 0 || xs == (H_ACTIVE-1)>>THICK_BITS || ys == 0 || ys == (V_ACTIVE-1)>>THICK_BITS).
  - xs = x_pos >> THICK_BITS, ys = y_pos >> THICK_BITS, compared unsigned at BIT-THICK_BITS width.
  - With the defaults, the border covers columns 0–15 and 624–639, and rows 0–15 and 464–479.
- FSM states: IDLE, FLASH_ON, FLASH_OFF.
- Counters:
  - frame_cnt: $clog2(FLASH_FRAMES) bits, minimum 1 bit.
  - cyc_cnt: $clog2(FLASH_CYCLES+1) bits.
- flash_req in any state:
  - go to FLASH_ON, frame_cnt=0, cyc_cnt=0.
  - A retrigger mid-sequence restarts the sequence from the beginning.
- In FLASH_ON/FLASH_OFF, each frame_start:
  - If frame_cnt == FLASH_FRAMES-1, set frame_cnt=0 and change phase.
  - Otherwise, frame_cnt+1.
- Phase changes:
  - FLASH_ON → FLASH_OFF.
  - FLASH_OFF → FLASH_ON with cyc_cnt+1. If that new cyc_cnt == FLASH_CYCLES, go to IDLE instead.
- flash_req and frame_start in the same cycle: flash_req wins and the frame_start is ignored.
- frame_start in IDLE: no effect.
- Output selection, per state:
  - IDLE: border_active=hit, rgb = hit ? COLOR : 0.
  - FLASH_ON: border_active=hit, rgb = hit ? FLASH_COLOR : 0.
  - FLASH_OFF: border_active=0, rgb=0 (border hidden).
- flash_busy = (state != IDLE), registered.

## Timing
- Reset values: state=IDLE, frame_cnt=0, cyc_cnt=0, border_active=0, rgb=3'b000, flash_busy=0. Reset takes effect immediately and asynchronously, including mid-flash.
- Pixel latency is 1 cycle. Outputs at edge N+1 reflect x_pos/y_pos sampled at edge N, combined with the state as it was before edge N.
- State updates are registered:
  - A flash_req sampled at edge N sets state=FLASH_ON after edge N.
  - The first recoloured pixel appears on the outputs after edge N+1.
  - flash_busy rises after edge N.
- Sequence length is exactly 2·FLASH_FRAMES·FLASH_CYCLES frame_start pulses, counted after the request; the default is 64. flash_busy falls after the edge that samples the final frame_start.
- No handshake: flash_req is a single pulse and is never dropped.

## Test plan
- Reset, then sweep (x,y) = (0,100),(15,100),(16,100),(623,200),(624,200),(639,200),(320,479),(320,463) → one cycle later border_active = 1,1,0,0,1,1,1,0, with rgb=3'b111 wherever active and 3'b000 elsewhere.
- Off-screen positions (700,10) and (10,500) → border_active=0, rgb=0.
- Flash sequence:
  - Pulse flash_req with the pixel held at (0,0). flash_busy=1 next cycle, rgb=3'b100 for 8 frame_starts, then border_active=0/rgb=0 for 8 frame_starts.
  - The pattern repeats 4 times.
  - After the 64th frame_start: flash_busy=0 and rgb=3'b111.
- Retrigger: flash_req after 20 frame_starts → sequence restarts in FLASH_ON, and flash_busy stays high for 64 more frame_starts.
- Simultaneous flash_req+frame_start while in FLASH_OFF with frame_cnt=7 → state=FLASH_ON, frame_cnt=0, and no phase advance.
- Assert reset mid-flash, in the FLASH_OFF phase → outputs 0 and flash_busy=0 immediately. After release, pixel (0,0) gives rgb=3'b111.
